simple_out_capture: RTL and testbench
=====================================

// Module: simple_out_capture
// PURPOSE
//   Downstream consumer of the 1-bit registered output "out" of the simple gate-level
//   netlist (INV chain after DFF f1). Samples out one bit per iccad_clk cycle while
//   capture is enabled. Packs WIDTH consecutive bits MSB-first into words and buffers
//   them in a DEPTH-entry FIFO with a valid/ready read port.
//   Also counts transitions on out and flags FIFO overflow, for netlist sign-off checks.
// PARAMETERS
//   WIDTH  8  bits per packed word (>=2)
//   DEPTH  4  FIFO entries (power of 2, >=2)
//   CNT_W  16 width of saturating transition counter
// PORTS
//   iccad_clk    in   1              single clock; all logic on rising edge
//   iccad_rst_n  in   1              reset; synchronous, active-low
//   out_i        in   1              serial bit from upstream netlist output "out"
//   cap_en       in   1              capture enable; high = sample out_i this cycle
//   word_data    out  WIDTH          FIFO head word
//   word_valid   out  1              FIFO non-empty
//   word_ready   in   1              consumer accepts head when word_valid&word_ready
//   fifo_level   out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
//   overflow     out  1              sticky: a completed word was dropped (FIFO full)
//   abort_cnt    out  8              saturating count of partial words discarded
//   edge_cnt     out  CNT_W          saturating count of out_i transitions while cap_en
// BEHAVIOUR
//   Reset (iccad_rst_n==0 at a rising edge): FSM=IDLE, bit_cnt=0, shift reg=0, FIFO
//     empty, word_valid=0, word_data=0, fifo_level=0, overflow=0, abort_cnt=0,
//     edge_cnt=0, prev_bit=0. Reset mid-word discards the partial word silently
//     (abort_cnt not incremented). Reset dominates all other inputs.
//   FSM:
//     IDLE : cap_en=1 -> sample out_i as bit 0 of a new word, bit_cnt=1, go SHIFT.
//            cap_en=0 -> stay.
//     SHIFT: cap_en=1 -> shift {sr[WIDTH-2:0],out_i}, bit_cnt++.
//            On the WIDTH-th sample, push the word in the same edge and set bit_cnt=0.
//            If cap_en is still 1 on the next cycle, the next word starts with no gap.
//            cap_en=0 with bit_cnt!=0 -> discard partial word, abort_cnt++ (sat 255),
//            go IDLE.
//   Bit order: first sampled bit lands in word_data[WIDTH-1].
//   Latency: word_valid rises the cycle after the edge that samples the last bit.
//     There is no bypass path from push to the read port when the FIFO is empty.
//   FIFO push/pop, same edge:
//     - Pop happens when word_valid&word_ready.
//     - Push while full with no pop: word dropped, overflow<=1 (until reset),
//       FIFO contents unchanged.
//     - Push and pop while full: both take effect; level stays DEPTH; no overflow.
//     - Push and pop while level==1: new word becomes head; level stays 1.
//     - word_ready while empty: ignored.
//     - Pointers wrap modulo DEPTH.
//   word_data is stable while word_valid=1 and word_ready=0.
//   edge_cnt: when cap_en=1 and out_i!=prev_bit, increment; saturate at 2^CNT_W-1.
//     prev_bit<=out_i every cycle, regardless of cap_en.
// TESTING (WIDTH=8, DEPTH=4)
//   1. Reset release, cap_en=1 for 8 cycles with out_i=1,0,1,1,0,0,1,0, word_ready=0
//      -> word_valid=1 next cycle; word_data=8'hB2; fifo_level=1; edge_cnt=6.
//   2. cap_en=1 for 40 cycles, word_ready=0 -> 5 words completed; level=4;
//      overflow=1 after the 5th; head = 1st word.
//   3. FIFO full, word_ready=1 on the cycle the 5th word completes -> no overflow;
//      level=4; new head = 2nd word.
//   4. cap_en drops after 3 bits -> FSM IDLE; abort_cnt=1; level unchanged;
//      next word restarts at MSB.
//   5. iccad_rst_n=0 for 1 cycle mid-word with 2 words queued -> all outputs at reset
//      values; abort_cnt=0.
//   6. out_i toggled every cycle for 70000 cycles, cap_en=1, CNT_W=16
//      -> edge_cnt holds at 16'hFFFF.

Source files
------------

// File: rtl/simple_out_capture.sv
// Packs the serial netlist output into WIDTH-bit words, MSB first, and queues them in a DEPTH-entry FIFO; also counts transitions and aborts.
// Latency: word_valid rises one cycle after the edge that samples the last bit (no empty-FIFO bypass).
// Backpressure: word_ready low holds the head word stable; a word completed while the FIFO is full with no pop is dropped and sets sticky overflow.
module simple_out_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     iccad_clk,
  input  logic                     iccad_rst_n,
  input  logic                     out_i,
  input  logic                     cap_en,
  output logic [WIDTH-1:0]         word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [7:0]               abort_cnt,
  output logic [CNT_W-1:0]         edge_cnt
);

  localparam int BW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  logic             state;
  logic [BW-1:0]    bit_cnt;
  logic [WIDTH-2:0] sr;          // only the low WIDTH-1 bits ever feed a future word
  logic             prev_bit;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  logic [WIDTH-1:0] new_word;
  logic             word_done;
  logic             full;
  logic             pop;
  logic             push_ok;
  logic             drop;

  assign word_valid = (fifo_level != '0);
  assign word_data  = word_valid ? mem[rd_ptr] : '0;

  // Completion of a word and the resulting FIFO push/pop/drop decisions for this edge
  always_comb begin
    new_word  = {sr, out_i};
    word_done = (state == S_SHIFT) && cap_en && (bit_cnt == LAST_BIT);
    full      = (fifo_level == LW'(DEPTH));
    pop       = word_valid && word_ready;
    push_ok   = word_done && (!full || pop);
    drop      = word_done && full && !pop;
  end

  // Capture FSM: bit sampling, word assembly and partial-word abort counting
  always_ff @(posedge iccad_clk) begin
    if (!iccad_rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      abort_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (cap_en) begin
        sr      <= (WIDTH-1)'(out_i);
        bit_cnt <= BW'(1);
        state   <= S_SHIFT;
      end
    end else begin
      if (cap_en) begin
        sr      <= new_word[WIDTH-2:0];
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
      end else begin
        state   <= S_IDLE;
        bit_cnt <= '0;
        if (bit_cnt != '0 && abort_cnt != 8'hFF)
          abort_cnt <= abort_cnt + 8'd1;
      end
    end
  end

  // FIFO storage; pointers reset separately so the array itself needs no reset
  always_ff @(posedge iccad_clk) begin
    if (iccad_rst_n && push_ok)
      mem[wr_ptr] <= new_word;
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge iccad_clk) begin
    if (!iccad_rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop)
        fifo_level <= fifo_level + LW'(1);
      else if (pop && !push_ok)
        fifo_level <= fifo_level - LW'(1);
      if (drop)
        overflow <= 1'b1;
    end
  end

  // Saturating transition counter; prev_bit tracks out_i even while capture is off
  always_ff @(posedge iccad_clk) begin
    if (!iccad_rst_n) begin
      prev_bit <= 1'b0;
      edge_cnt <= '0;
    end else begin
      prev_bit <= out_i;
      if (cap_en && (out_i != prev_bit) && (edge_cnt != '1))
        edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_simple_out_capture.sv
// Randomised and directed stimulus for simple_out_capture, scored against a queue-based behavioural model.
// The driver advances the model each cycle and pushes accepted words into a scoreboard queue.
// A separate monitor compares DUT outputs before each rising edge and pops words on handshakes.
module tb_simple_out_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             iccad_rst_n = 1'b0;
  logic             out_i = 1'b0;
  logic             cap_en = 1'b0;
  logic             word_ready = 1'b0;
  logic [WIDTH-1:0] word_data;
  logic             word_valid;
  logic [2:0]       fifo_level;
  logic             overflow;
  logic [7:0]       abort_cnt;
  logic [CNT_W-1:0] edge_cnt;

  simple_out_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .iccad_clk   (clk),
    .iccad_rst_n (iccad_rst_n),
    .out_i       (out_i),
    .cap_en      (cap_en),
    .word_data   (word_data),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .fifo_level  (fifo_level),
    .overflow    (overflow),
    .abort_cnt   (abort_cnt),
    .edge_cnt    (edge_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state (after the most recently stepped edge)
  logic             m_bits[$];
  int               m_level = 0;
  logic             m_ovf = 1'b0;
  int               m_abort = 0;
  int               m_edge = 0;
  logic             m_prev = 1'b0;
  logic             rst_done = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  // Snapshot of what the DUT should show during the current cycle
  logic snap_ok = 1'b0;
  int   e_level = 0;
  logic e_ovf = 1'b0;
  int   e_abort = 0;
  int   e_edge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the model across the coming edge
  task automatic step(input logic r, input logic c, input logic b, input logic rd);
    logic [WIDTH-1:0] w;
    logic pop;
    logic done;
    @(negedge clk);
    snap_ok = rst_done;
    e_level = m_level;
    e_ovf   = m_ovf;
    e_abort = m_abort;
    e_edge  = m_edge;
    iccad_rst_n = r;
    cap_en      = c;
    out_i       = b;
    word_ready  = r ? rd : 1'b0;
    w = '0;
    if (!r) begin
      m_bits.delete();
      exp_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      m_abort = 0;
      m_edge  = 0;
      m_prev  = 1'b0;
      rst_done = 1'b1;
    end else begin
      pop  = (m_level > 0) && rd;
      done = 1'b0;
      if (c) begin
        if (b != m_prev && m_edge < (1 << CNT_W) - 1) m_edge++;
        m_bits.push_back(b);
        if (m_bits.size() == WIDTH) begin
          foreach (m_bits[i]) w = {w[WIDTH-2:0], m_bits[i]};
          m_bits.delete();
          done = 1'b1;
        end
      end else if (m_bits.size() != 0) begin
        m_bits.delete();
        if (m_abort < 255) m_abort++;
      end
      m_prev = b;
      if (done) begin
        if (m_level < DEPTH || pop) begin
          exp_q.push_back(w);
          if (!pop) m_level++;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (pop) begin
        m_level--;
      end
    end
  endtask

  // Monitor: checks DUT outputs just before each rising edge and scores handshakes
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (snap_ok) begin
        chk("fifo_level", 32'(fifo_level), e_level);
        chk("word_valid", 32'(word_valid), 32'(e_level != 0));
        chk("overflow",   32'(overflow),   32'(e_ovf));
        chk("abort_cnt",  32'(abort_cnt),  e_abort);
        chk("edge_cnt",   32'(edge_cnt),   e_edge);
        if (iccad_rst_n && word_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: DUT presents %0h but no word expected at %0t", word_data, $time);
          end else begin
            chk("word_data", 32'(word_data), 32'(exp_q[0]));
            if (word_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  logic [7:0] pat;

  initial begin
    // Test 1: reset then the 1,0,1,1,0,0,1,0 pattern
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    pat = 8'b1011_0010;
    for (int i = 7; i >= 0; i--) step(1, 1, pat[i], 0);
    step(1, 0, 0, 0);
    #1;
    chk("t1_word_data", 32'(word_data), 32'h0000_00B2);
    chk("t1_word_valid", 32'(word_valid), 32'd1);
    chk("t1_fifo_level", 32'(fifo_level), 32'd1);
    chk("t1_edge_cnt", 32'(edge_cnt), 32'd6);

    // Test 2: 40 captured bits with no reads -> overflow
    step(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 1'($urandom), 0);
    step(1, 0, 0, 0);
    #1;
    chk("t2_overflow", 32'(overflow), 32'd1);
    chk("t2_fifo_level", 32'(fifo_level), 32'd4);

    // Test 3: pop on the exact cycle the fifth word completes
    step(0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(1, 1, 1'($urandom), (i == 39));
    step(1, 0, 0, 0);
    #1;
    chk("t3_overflow", 32'(overflow), 32'd0);

    // Test 4: abort after 3 bits, then a full word from MSB
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1'($urandom), 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1'($urandom), 0);
    step(1, 0, 0, 1);
    #1;
    chk("t4_abort_cnt", 32'(abort_cnt), 32'd1);

    // Test 5: reset mid-word with two words queued
    for (int i = 0; i < 20; i++) step(1, 1, 1'($urandom), 0);
    step(0, 1, 1, 0);
    step(1, 0, 0, 0);
    #1;
    chk("t5_abort_cnt", 32'(abort_cnt), 32'd0);
    chk("t5_word_valid", 32'(word_valid), 32'd0);

    // Random phase: bursty capture, random reads, rare resets
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 15) != 0),
           1'($urandom), ($urandom_range(0, 2) == 0));

    // Test 6: continuous toggling saturates the transition counter
    step(0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(1, 1, ((i & 1) == 0), 1);
    step(1, 0, 0, 1);
    #1;
    chk("t6_edge_cnt", 32'(edge_cnt), 32'h0000_FFFF);

    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    @(negedge clk);
    #4;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
